// File: rtl/equ_pkg.sv
// Shared definitions for the equality-checker stimulus generator:
// FSM encoding, LFSR taps/seed and the LFSR step helpers.
package equ_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h00A5;

    // One left shift of the Fibonacci LFSR x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    // An all-zero state would lock the LFSR, so zero seeds become 1.
    function automatic logic [15:0] eff_seed(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and single-step enable.
// q holds the value of the vector currently being presented.
module lfsr16
    import equ_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= eff_seed(seed);
        end else if (load) begin
            q_reg <= eff_seed(seed);
        end else if (step) begin
            q_reg <= lfsr_next(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/equ_vec_gen.sv
// Stimulus source for equality checkers: issues x/y pairs with the expected
// compare result over valid/ready, exhaustively or from an LFSR.
module equ_vec_gen
    import equ_pkg::*;
#(
    parameter int          W         = 2,
    parameter int          NUM_VEC   = 16,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic         rdy,
    output logic         vld,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         z_exp,
    output logic         busy,
    output logic         done,
    output logic [15:0]  vec_cnt
);

    localparam int          IW       = 2 * W;
    localparam logic [15:0] SEED_EFF = eff_seed(LFSR_SEED);
    localparam logic [15:0] LAST_CNT = 16'(NUM_VEC - 1);

    state_t          state_reg, state_next;
    logic            mode_reg;
    logic [IW-1:0]   idx_reg;
    logic [15:0]     vec_cnt_reg;
    logic [W-1:0]    x_reg, y_reg;
    logic            z_reg;
    logic [15:0]     lfsr_q;

    logic            start_acc;
    logic            xfer;
    logic            last_vec;
    logic            advance;
    logic            load_vec;
    logic            mode_sel;
    logic [IW-1:0]   src;
    logic [W-1:0]    x_next, y_next;

    // start is honoured only outside RUN.
    assign start_acc = start && (state_reg != RUN);
    assign xfer      = (state_reg == RUN) && rdy;
    assign last_vec  = mode_reg ? (vec_cnt_reg == LAST_CNT) : (&idx_reg);
    // The last transfer leaves x/y/z holding the final pair.
    assign advance   = xfer && !last_vec;
    assign load_vec  = start_acc || advance;
    assign mode_sel  = start_acc ? mode : mode_reg;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .seed  (LFSR_SEED),
        .step  (advance),
        .q     (lfsr_q)
    );

    // Source bits of the next vector; the LFSR path looks one step ahead so
    // the registered pair lines up with the LFSR state after the step.
    always_comb begin
        src = '0;
        if (start_acc) begin
            src = mode ? SEED_EFF[IW-1:0] : '0;
        end else if (mode_reg) begin
            src = IW'(lfsr_next(lfsr_q));
        end else begin
            src = idx_reg + IW'(1);
        end
    end

    // Exhaustive takes x from the upper half; LFSR takes x from the lower half.
    always_comb begin
        x_next = '0;
        y_next = '0;
        if (mode_sel) begin
            x_next = src[W-1:0];
            y_next = src[IW-1:W];
        end else begin
            x_next = src[IW-1:W];
            y_next = src[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (xfer && last_vec) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vld  = (state_reg == RUN);
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg    <= 1'b0;
            idx_reg     <= '0;
            vec_cnt_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            z_reg       <= 1'b0;
        end else begin
            if (start_acc) begin
                mode_reg    <= mode;
                idx_reg     <= '0;
                vec_cnt_reg <= '0;
            end else begin
                if (advance) begin
                    idx_reg <= idx_reg + IW'(1);
                end
                if (xfer) begin
                    vec_cnt_reg <= vec_cnt_reg + 16'd1;
                end
            end
            if (load_vec) begin
                x_reg <= x_next;
                y_reg <= y_next;
                z_reg <= (x_next == y_next);
            end
        end
    end

    assign x_out   = x_reg;
    assign y_out   = y_reg;
    assign z_exp   = z_reg;
    assign vec_cnt = vec_cnt_reg;

endmodule

// File: tb/tb_equ_vec_gen.sv
// Directed bench for equ_vec_gen: exhaustive walk, backpressure, LFSR mode,
// start-in-RUN, mid-run reset and the zero-seed substitution.
module tb_equ_vec_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, rdy;
    logic        vld, z_exp, busy, done;
    logic [1:0]  x_out, y_out;
    logic [15:0] vec_cnt;

    logic        rst_n_z, start_z, mode_z, rdy_z;
    logic        vld_z, z_exp_z, busy_z, done_z;
    logic [1:0]  x_out_z, y_out_z;
    logic [15:0] vec_cnt_z;

    int n_cmp  = 0;
    int n_fail = 0;

    equ_vec_gen #(.W(2), .NUM_VEC(4), .LFSR_SEED(16'h00A5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rdy(rdy),
        .vld(vld), .x_out(x_out), .y_out(y_out), .z_exp(z_exp),
        .busy(busy), .done(done), .vec_cnt(vec_cnt)
    );

    equ_vec_gen #(.W(2), .NUM_VEC(100), .LFSR_SEED(16'h0000)) dut_z (
        .clk(clk), .rst_n(rst_n_z), .start(start_z), .mode(mode_z), .rdy(rdy_z),
        .vld(vld_z), .x_out(x_out_z), .y_out(y_out_z), .z_exp(z_exp_z),
        .busy(busy_z), .done(done_z), .vec_cnt(vec_cnt_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exhaustive vector i: x = i[3:2], y = i[1:0].
    task automatic check_vec(input string tag, input int i, input int cnt);
        logic [3:0] iv;
        iv = 4'(i);
        check({tag, "_vld"}, 32'(vld), 32'd1);
        check({tag, "_x"}, 32'(x_out), 32'(iv[3:2]));
        check({tag, "_y"}, 32'(y_out), 32'(iv[1:0]));
        check({tag, "_z"}, 32'(z_exp), 32'(iv[3:2] == iv[1:0]));
        check({tag, "_cnt"}, 32'(vec_cnt), 32'(cnt));
        $display("%s idx=%0d x=%b y=%b z=%b cnt=%0d", tag, i, x_out, y_out, z_exp, vec_cnt);
    endtask

    initial begin
        logic [1:0]  lx [4];
        logic [1:0]  ly [4];
        logic [15:0] m;

        // LFSR from 0x00A5: 00A5, 014A, 0294, 0528 -> x = bits[1:0], y = bits[3:2]
        lx[0] = 2'b01; ly[0] = 2'b01;
        lx[1] = 2'b10; ly[1] = 2'b10;
        lx[2] = 2'b00; ly[2] = 2'b01;
        lx[3] = 2'b00; ly[3] = 2'b10;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; rdy = 1'b1;
        rst_n_z = 1'b0; start_z = 1'b0; mode_z = 1'b1; rdy_z = 1'b1;
        repeat (3) tick();
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_xy", 32'({x_out, y_out, z_exp}), 32'd0);
        check("rst_cnt", 32'(vec_cnt), 32'd0);
        rst_n = 1'b1; rst_n_z = 1'b1;
        tick();
        check("idle_vld", 32'(vld), 32'd0);

        // 1: exhaustive, rdy high
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_vec("t1", i, i);
            tick();
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_vld", 32'(vld), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_cnt", 32'(vec_cnt), 32'd16);
        check("t1_hold_xy", 32'({x_out, y_out}), 32'hF);
        rdy = 1'b0; tick(); rdy = 1'b1; tick();
        check("t1_done_hold", 32'(done), 32'd1);
        check("t1_cnt_hold", 32'(vec_cnt), 32'd16);

        // 2: backpressure on vector 5
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                rdy = 1'b0;
                repeat (3) begin
                    check_vec("t2_hold", 5, 5);
                    tick();
                end
                rdy = 1'b1;
            end
            check_vec("t2", i, i);
            tick();
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_cnt", 32'(vec_cnt), 32'd16);

        // 3: LFSR mode; mode changes after start must not matter
        mode = 1'b1; start = 1'b1; tick(); start = 1'b0; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t3_vld", 32'(vld), 32'd1);
            check("t3_x", 32'(x_out), 32'(lx[k]));
            check("t3_y", 32'(y_out), 32'(ly[k]));
            check("t3_z", 32'(z_exp), 32'(lx[k] == ly[k]));
            check("t3_cnt", 32'(vec_cnt), 32'(k));
            $display("t3 k=%0d x=%b y=%b z=%b cnt=%0d", k, x_out, y_out, z_exp, vec_cnt);
            tick();
        end
        check("t3_done", 32'(done), 32'd1);
        check("t3_vld_end", 32'(vld), 32'd0);
        check("t3_cnt_end", 32'(vec_cnt), 32'd4);

        // 4: start in RUN ignored, start in DONE restarts
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_vec("t4", i, i);
            if (i == 7) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_cnt", 32'(vec_cnt), 32'd16);
        start = 1'b1; tick(); start = 1'b0;
        check_vec("t4_restart", 0, 0);

        // 5: reset at vector 9
        for (int i = 0; i < 9; i++) begin
            check_vec("t5", i, i);
            tick();
        end
        check_vec("t5", 9, 9);
        rst_n = 1'b0;
        #1;
        check("t5_rst_vld", 32'(vld), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_cnt", 32'(vec_cnt), 32'd0);
        check("t5_rst_xyz", 32'({x_out, y_out, z_exp}), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t5_idle_vld", 32'(vld), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check_vec("t5_restart", 0, 0);
        tick();
        check_vec("t5_restart", 1, 1);

        // 6: zero seed becomes 0x0001; independent reference LFSR
        start_z = 1'b1; tick(); start_z = 1'b0;
        check("t6_first_x", 32'(x_out_z), 32'd1);
        check("t6_first_y", 32'(y_out_z), 32'd0);
        check("t6_first_z", 32'(z_exp_z), 32'd0);
        m = 16'h0001;
        for (int k = 0; k < 100; k++) begin
            check("t6_vld", 32'(vld_z), 32'd1);
            check("t6_xy", 32'({x_out_z, y_out_z}), 32'({m[1:0], m[3:2]}));
            check("t6_z", 32'(z_exp_z), 32'(m[1:0] == m[3:2]));
            if (k % 20 == 0)
                $display("t6 k=%0d x=%b y=%b z=%b", k, x_out_z, y_out_z, z_exp_z);
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
            tick();
        end
        check("t6_done", 32'(done_z), 32'd1);
        check("t6_cnt", 32'(vec_cnt_z), 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
